xf100_exu_wbck_arb: RTL and testbench

Writeback arbiter for the xf100 EXU. It shares the single integer regfile write port between the single-cycle ALU result path and the long-latency result path (LSU/MULDIV). Long-path results are held in a small FIFO; the ALU has fixed priority, bounded by a starvation counter. The registered winner drives the regfile write port.

---
 rtl/xf100_exu_wbck_pkg.sv | 20 ++
 rtl/xf100_exu_wbck_fifo.sv | 50 +++++
 rtl/xf100_exu_wbck_arb.sv | 101 ++++++++++
 tb/tb_xf100_exu_wbck_arb.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/xf100_exu_wbck_pkg.sv
// Shared widths, parameter defaults and types for the xf100 EXU writeback arbiter.
package xf100_exu_wbck_pkg;

  localparam int XF100_XLEN                = 32;
  localparam int XF100_RFIDX_WIDTH         = 5;
  localparam int XF100_WBCK_LNG_FIFO_DEPTH = 2;
  localparam int XF100_WBCK_STARVE_MAX     = 4;

  typedef struct packed {
    logic [XF100_RFIDX_WIDTH-1:0] rdidx;
    logic [XF100_XLEN-1:0]        data;
  } wbck_entry_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_ALU,
    GNT_LNG
  } wbck_gnt_e;

endpackage

// File: rtl/xf100_exu_wbck_fifo.sv
// Generic synchronous FIFO with occupancy count; pushes while full and pops while
// empty are ignored, so a full FIFO never accepts even alongside a pop.
module xf100_exu_wbck_fifo #(
  parameter int DW    = 37,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  output logic [DW-1:0]            pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   cnt
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (cnt == (AW+1)'(DEPTH));
  assign empty    = (cnt == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // Storage needs no reset; the count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      cnt <= cnt + 1'b1;
      else if (do_pop && !do_push) cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/xf100_exu_wbck_arb.sv
// Shares the regfile write port between the ALU and the queued long-latency path;
// ALU has priority until the queued head has waited STARVE_MAX cycles.
module xf100_exu_wbck_arb
  import xf100_exu_wbck_pkg::*;
#(
  parameter int LNG_FIFO_DEPTH = XF100_WBCK_LNG_FIFO_DEPTH,
  parameter int STARVE_MAX     = XF100_WBCK_STARVE_MAX
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             alu_i_valid,
  output logic                             alu_o_ready,
  input  logic [XF100_XLEN-1:0]            alu_i_data,
  input  logic [XF100_RFIDX_WIDTH-1:0]     alu_i_rdidx,
  input  logic                             lng_i_valid,
  output logic                             lng_o_ready,
  input  logic [XF100_XLEN-1:0]            lng_i_data,
  input  logic [XF100_RFIDX_WIDTH-1:0]     lng_i_rdidx,
  output logic                             lng_o_pend,
  output logic [$clog2(LNG_FIFO_DEPTH):0]  lng_o_cnt,
  output logic                             wbck_o_wbck_en,
  output logic [XF100_XLEN-1:0]            wbck_o_wbck_data,
  output logic [XF100_RFIDX_WIDTH-1:0]     wbck_o_wbck_rdidx
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  wbck_entry_t lng_push_entry;
  wbck_entry_t lng_head;
  wbck_entry_t win_entry;
  wbck_gnt_e   gnt;
  logic [3:0]  starve_cnt;
  logic        fifo_full;
  logic        fifo_empty;
  logic        force_lng;
  logic        lng_push;
  logic        lng_pop;

  assign lng_push_entry = '{rdidx: lng_i_rdidx, data: lng_i_data};
  assign lng_push       = lng_i_valid & lng_o_ready;
  assign lng_pop        = (gnt == GNT_LNG);

  xf100_exu_wbck_fifo #(
    .DW    ($bits(wbck_entry_t)),
    .DEPTH (LNG_FIFO_DEPTH)
  ) u_lng_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (lng_push),
    .push_data (lng_push_entry),
    .pop       (lng_pop),
    .pop_data  (lng_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .cnt       (lng_o_cnt)
  );

  // Both readies come from registered state only, so no valid->ready path exists.
  assign lng_o_pend  = ~fifo_empty;
  assign lng_o_ready = ~fifo_full;
  assign force_lng   = lng_o_pend & (starve_cnt == STARVE_LIM);
  assign alu_o_ready = ~force_lng;

  always_comb begin
    gnt = GNT_NONE;
    if (force_lng)        gnt = GNT_LNG;
    else if (alu_i_valid) gnt = GNT_ALU;
    else if (lng_o_pend)  gnt = GNT_LNG;
  end

  always_comb begin
    win_entry = lng_head;
    if (gnt == GNT_ALU) win_entry = '{rdidx: alu_i_rdidx, data: alu_i_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (fifo_empty || lng_pop) begin
      starve_cnt <= '0;
    end else if (starve_cnt != STARVE_LIM) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Writes to x0 still consume the grant but leave the enable low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbck_o_wbck_en    <= 1'b0;
      wbck_o_wbck_data  <= '0;
      wbck_o_wbck_rdidx <= '0;
    end else if (gnt != GNT_NONE) begin
      wbck_o_wbck_en    <= (win_entry.rdidx != '0);
      wbck_o_wbck_data  <= win_entry.data;
      wbck_o_wbck_rdidx <= win_entry.rdidx;
    end else begin
      wbck_o_wbck_en    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_xf100_exu_wbck_arb.sv
// Directed self-checking bench for the writeback arbiter with default parameters.
module tb_xf100_exu_wbck_arb;

  logic        clk;
  logic        rst_n;
  logic        alu_i_valid;
  logic        alu_o_ready;
  logic [31:0] alu_i_data;
  logic [4:0]  alu_i_rdidx;
  logic        lng_i_valid;
  logic        lng_o_ready;
  logic [31:0] lng_i_data;
  logic [4:0]  lng_i_rdidx;
  logic        lng_o_pend;
  logic [1:0]  lng_o_cnt;
  logic        wbck_o_wbck_en;
  logic [31:0] wbck_o_wbck_data;
  logic [4:0]  wbck_o_wbck_rdidx;

  int n_checks;
  int n_fail;

  xf100_exu_wbck_arb dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .alu_i_valid       (alu_i_valid),
    .alu_o_ready       (alu_o_ready),
    .alu_i_data        (alu_i_data),
    .alu_i_rdidx       (alu_i_rdidx),
    .lng_i_valid       (lng_i_valid),
    .lng_o_ready       (lng_o_ready),
    .lng_i_data        (lng_i_data),
    .lng_i_rdidx       (lng_i_rdidx),
    .lng_o_pend        (lng_o_pend),
    .lng_o_cnt         (lng_o_cnt),
    .wbck_o_wbck_en    (wbck_o_wbck_en),
    .wbck_o_wbck_data  (wbck_o_wbck_data),
    .wbck_o_wbck_rdidx (wbck_o_wbck_rdidx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_checks++; if (wbck_o_wbck_en !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_en: got %0h expected 0", wbck_o_wbck_en); end
    n_checks++; if (wbck_o_wbck_data !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_data: got %0h expected 0", wbck_o_wbck_data); end
    n_checks++; if (wbck_o_wbck_rdidx !== 5'd0) begin n_fail++; $display("[TB] FAIL rst_rdidx: got %0h expected 0", wbck_o_wbck_rdidx); end
    n_checks++; if (lng_o_cnt !== 2'd0) begin n_fail++; $display("[TB] FAIL rst_cnt: got %0h expected 0", lng_o_cnt); end
    n_checks++; if (lng_o_pend !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_pend: got %0h expected 0", lng_o_pend); end
    n_checks++; if (lng_o_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_lng_ready: got %0h expected 1", lng_o_ready); end
    n_checks++; if (alu_o_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_alu_ready: got %0h expected 1", alu_o_ready); end
  endtask

  task automatic test_alu_only();
    alu_i_valid = 1'b1; alu_i_rdidx = 5'd5; alu_i_data = 32'h1234;
    n_checks++; if (alu_o_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL alu_ready: got %0h expected 1", alu_o_ready); end
    step();
    alu_i_valid = 1'b0;
    n_checks++; if (wbck_o_wbck_en !== 1'b1) begin n_fail++; $display("[TB] FAIL alu_en: got %0h expected 1", wbck_o_wbck_en); end
    n_checks++; if (wbck_o_wbck_rdidx !== 5'd5) begin n_fail++; $display("[TB] FAIL alu_rdidx: got %0h expected 5", wbck_o_wbck_rdidx); end
    n_checks++; if (wbck_o_wbck_data !== 32'h1234) begin n_fail++; $display("[TB] FAIL alu_data: got %0h expected 1234", wbck_o_wbck_data); end
    step();
    n_checks++; if (wbck_o_wbck_en !== 1'b0) begin n_fail++; $display("[TB] FAIL alu_idle_en: got %0h expected 0", wbck_o_wbck_en); end
    n_checks++; if (wbck_o_wbck_data !== 32'h1234) begin n_fail++; $display("[TB] FAIL alu_hold_data: got %0h expected 1234", wbck_o_wbck_data); end
  endtask

  task automatic test_long_only();
    lng_i_valid = 1'b1; lng_i_rdidx = 5'd7; lng_i_data = 32'hA5A5;
    step();
    lng_i_valid = 1'b0;
    n_checks++; if (wbck_o_wbck_en !== 1'b0) begin n_fail++; $display("[TB] FAIL lng_no_bypass: got %0h expected 0", wbck_o_wbck_en); end
    n_checks++; if (lng_o_cnt !== 2'd1) begin n_fail++; $display("[TB] FAIL lng_cnt1: got %0h expected 1", lng_o_cnt); end
    step();
    n_checks++; if (wbck_o_wbck_en !== 1'b1) begin n_fail++; $display("[TB] FAIL lng_en: got %0h expected 1", wbck_o_wbck_en); end
    n_checks++; if (wbck_o_wbck_rdidx !== 5'd7) begin n_fail++; $display("[TB] FAIL lng_rdidx: got %0h expected 7", wbck_o_wbck_rdidx); end
    n_checks++; if (wbck_o_wbck_data !== 32'hA5A5) begin n_fail++; $display("[TB] FAIL lng_data: got %0h expected a5a5", wbck_o_wbck_data); end
    n_checks++; if (lng_o_cnt !== 2'd0) begin n_fail++; $display("[TB] FAIL lng_cnt0: got %0h expected 0", lng_o_cnt); end
  endtask

  task automatic test_fill_full();
    alu_i_valid = 1'b1; alu_i_rdidx = 5'd9; alu_i_data = 32'h9999;
    lng_i_valid = 1'b1; lng_i_rdidx = 5'd8; lng_i_data = 32'h1111;
    step();
    lng_i_rdidx = 5'd10; lng_i_data = 32'h2222;
    step();
    n_checks++; if (lng_o_cnt !== 2'd2) begin n_fail++; $display("[TB] FAIL full_cnt: got %0h expected 2", lng_o_cnt); end
    n_checks++; if (lng_o_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL full_ready: got %0h expected 0", lng_o_ready); end
    n_checks++; if (wbck_o_wbck_rdidx !== 5'd9) begin n_fail++; $display("[TB] FAIL full_alu_rdidx: got %0h expected 9", wbck_o_wbck_rdidx); end
    // Offer a third entry while full and popping: it must be refused.
    alu_i_valid = 1'b0;
    lng_i_rdidx = 5'd11; lng_i_data = 32'h3333;
    step();
    lng_i_valid = 1'b0;
    n_checks++; if (lng_o_cnt !== 2'd1) begin n_fail++; $display("[TB] FAIL full_no_accept: got %0h expected 1", lng_o_cnt); end
    n_checks++; if (wbck_o_wbck_data !== 32'h1111) begin n_fail++; $display("[TB] FAIL drain1_data: got %0h expected 1111", wbck_o_wbck_data); end
    step();
    n_checks++; if (wbck_o_wbck_rdidx !== 5'd10) begin n_fail++; $display("[TB] FAIL drain2_rdidx: got %0h expected a", wbck_o_wbck_rdidx); end
    n_checks++; if (lng_o_cnt !== 2'd0) begin n_fail++; $display("[TB] FAIL drain2_cnt: got %0h expected 0", lng_o_cnt); end
    step();
    n_checks++; if (wbck_o_wbck_en !== 1'b0) begin n_fail++; $display("[TB] FAIL refused_not_written: got %0h expected 0", wbck_o_wbck_en); end
  endtask

  task automatic test_starvation();
    alu_i_valid = 1'b1; alu_i_rdidx = 5'd3; alu_i_data = 32'h0100;
    lng_i_valid = 1'b1; lng_i_rdidx = 5'd12; lng_i_data = 32'hBEEF;
    step();
    lng_i_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      alu_i_data = 32'h0200 + i;
      n_checks++; if (alu_o_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL starve_ready_%0d: got %0h expected 1", i, alu_o_ready); end
      step();
      n_checks++; if (wbck_o_wbck_data !== 32'h0200 + i) begin n_fail++; $display("[TB] FAIL starve_alu_%0d: got %0h expected %0h", i, wbck_o_wbck_data, 32'h0200 + i); end
    end
    alu_i_data = 32'h0300;
    n_checks++; if (alu_o_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL force_ready: got %0h expected 0", alu_o_ready); end
    step();
    n_checks++; if (wbck_o_wbck_data !== 32'hBEEF) begin n_fail++; $display("[TB] FAIL force_data: got %0h expected beef", wbck_o_wbck_data); end
    n_checks++; if (wbck_o_wbck_rdidx !== 5'd12) begin n_fail++; $display("[TB] FAIL force_rdidx: got %0h expected c", wbck_o_wbck_rdidx); end
    n_checks++; if (alu_o_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL after_force_ready: got %0h expected 1", alu_o_ready); end
    step();
    alu_i_valid = 1'b0;
    n_checks++; if (wbck_o_wbck_data !== 32'h0300) begin n_fail++; $display("[TB] FAIL retry_data: got %0h expected 300", wbck_o_wbck_data); end
    n_checks++; if (wbck_o_wbck_rdidx !== 5'd3) begin n_fail++; $display("[TB] FAIL retry_rdidx: got %0h expected 3", wbck_o_wbck_rdidx); end
    step();
  endtask

  task automatic test_x0();
    alu_i_valid = 1'b1; alu_i_rdidx = 5'd0; alu_i_data = 32'hFFFF;
    step();
    alu_i_valid = 1'b0;
    n_checks++; if (wbck_o_wbck_en !== 1'b0) begin n_fail++; $display("[TB] FAIL x0_alu_en: got %0h expected 0", wbck_o_wbck_en); end
    n_checks++; if (wbck_o_wbck_data !== 32'hFFFF) begin n_fail++; $display("[TB] FAIL x0_alu_data: got %0h expected ffff", wbck_o_wbck_data); end
    lng_i_valid = 1'b1; lng_i_rdidx = 5'd0; lng_i_data = 32'h5555;
    step();
    lng_i_valid = 1'b0;
    n_checks++; if (lng_o_cnt !== 2'd1) begin n_fail++; $display("[TB] FAIL x0_lng_cnt1: got %0h expected 1", lng_o_cnt); end
    step();
    n_checks++; if (lng_o_cnt !== 2'd0) begin n_fail++; $display("[TB] FAIL x0_lng_pop: got %0h expected 0", lng_o_cnt); end
    n_checks++; if (wbck_o_wbck_en !== 1'b0) begin n_fail++; $display("[TB] FAIL x0_lng_en: got %0h expected 0", wbck_o_wbck_en); end
  endtask

  task automatic test_ordering();
    lng_i_valid = 1'b1; lng_i_rdidx = 5'd1; lng_i_data = 32'h1001;
    step();
    lng_i_rdidx = 5'd2; lng_i_data = 32'h1002;
    step();
    n_checks++; if (lng_o_cnt !== 2'd1) begin n_fail++; $display("[TB] FAIL pushpop_cnt: got %0h expected 1", lng_o_cnt); end
    n_checks++; if (wbck_o_wbck_rdidx !== 5'd1 || wbck_o_wbck_en !== 1'b1) begin n_fail++; $display("[TB] FAIL order1: got rdidx %0h en %0h expected rdidx 1 en 1", wbck_o_wbck_rdidx, wbck_o_wbck_en); end
    lng_i_rdidx = 5'd3; lng_i_data = 32'h1003;
    step();
    lng_i_valid = 1'b0;
    n_checks++; if (wbck_o_wbck_rdidx !== 5'd2 || wbck_o_wbck_data !== 32'h1002) begin n_fail++; $display("[TB] FAIL order2: got rdidx %0h data %0h expected rdidx 2 data 1002", wbck_o_wbck_rdidx, wbck_o_wbck_data); end
    step();
    n_checks++; if (wbck_o_wbck_rdidx !== 5'd3 || wbck_o_wbck_data !== 32'h1003) begin n_fail++; $display("[TB] FAIL order3: got rdidx %0h data %0h expected rdidx 3 data 1003", wbck_o_wbck_rdidx, wbck_o_wbck_data); end
    n_checks++; if (lng_o_cnt !== 2'd0) begin n_fail++; $display("[TB] FAIL order_cnt: got %0h expected 0", lng_o_cnt); end
    step();
  endtask

  task automatic test_reset_mid();
    alu_i_valid = 1'b1; alu_i_rdidx = 5'd4; alu_i_data = 32'h0044;
    lng_i_valid = 1'b1; lng_i_rdidx = 5'd13; lng_i_data = 32'hAAAA;
    step();
    lng_i_rdidx = 5'd14; lng_i_data = 32'hBBBB;
    step();
    n_checks++; if (lng_o_cnt !== 2'd2 || wbck_o_wbck_en !== 1'b1) begin n_fail++; $display("[TB] FAIL pre_reset: got cnt %0h en %0h expected cnt 2 en 1", lng_o_cnt, wbck_o_wbck_en); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (wbck_o_wbck_en !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_rst_en: got %0h expected 0", wbck_o_wbck_en); end
    n_checks++; if (wbck_o_wbck_data !== 32'h0 || wbck_o_wbck_rdidx !== 5'd0) begin n_fail++; $display("[TB] FAIL mid_rst_out: got data %0h rdidx %0h expected 0 0", wbck_o_wbck_data, wbck_o_wbck_rdidx); end
    n_checks++; if (lng_o_cnt !== 2'd0 || lng_o_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_rst_fifo: got cnt %0h ready %0h expected 0 1", lng_o_cnt, lng_o_ready); end
    alu_i_valid = 1'b0; lng_i_valid = 1'b0;
    #3 rst_n = 1'b1;
    step();
    step();
    n_checks++; if (wbck_o_wbck_en !== 1'b0 || lng_o_pend !== 1'b0) begin n_fail++; $display("[TB] FAIL post_rst_empty: got en %0h pend %0h expected 0 0", wbck_o_wbck_en, lng_o_pend); end
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    alu_i_valid = 1'b0;
    alu_i_data  = '0;
    alu_i_rdidx = '0;
    lng_i_valid = 1'b0;
    lng_i_data  = '0;
    lng_i_rdidx = '0;
    #2;
    test_reset();
    #10 rst_n = 1'b1;
    step();
    test_alu_only();
    test_long_only();
    test_fill_full();
    test_starvation();
    test_x0();
    test_ordering();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
